// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the reg_file write port between writeback and debug,
// with a starvation bound for debug and a zero-fill clear sequencer.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int MAX_WAIT       = 4,
  parameter int CLEAR_ON_RESET = 1,
  parameter int DROP_ZERO      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_clear,
  output logic                  clear_busy,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_ready,
  input  logic                  dbg_valid,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  dbg_ready,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_wrAddr,
  output logic [DATA_WIDTH-1:0] rf_wrData
);
  typedef enum logic {sClear, sRun} stateT;
  localparam stateT RESET_STATE = (CLEAR_ON_RESET != 0) ? sClear : sRun;
  stateT state, nextState;
  logic [ADDR_WIDTH-1:0] cnt, nextCnt, grantAddr, nextAddr;
  logic [DATA_WIDTH-1:0] grantData, nextData;
  logic [3:0] waitCnt, nextWait;
  logic starve, wbAcc, dbgAcc, nextWe;
  assign clear_busy = state == sClear;
  assign starve = waitCnt >= 4'(MAX_WAIT);
  // readies are gated by reset so nothing handshakes while the block is held in reset
  assign wb_ready = !reset && state == sRun && (!starve || !dbg_valid);
  assign dbg_ready = !reset && state == sRun && dbg_valid && (!wb_valid || starve);
  assign wbAcc = wb_valid && wb_ready;
  assign dbgAcc = dbg_valid && dbg_ready;
  assign grantAddr = wbAcc ? wb_addr : dbg_addr;
  assign grantData = wbAcc ? wb_data : dbg_data;
  always_comb begin
    nextState = state;
    nextCnt = cnt;
    nextWait = waitCnt;
    nextWe = 1'b0;
    nextAddr = rf_wrAddr;
    nextData = rf_wrData;
    if (state == sClear) begin
      nextWe = 1'b1;
      nextAddr = cnt;
      nextData = '0;
      nextCnt = cnt + 1'b1;
      nextWait = '0;
      nextState = (cnt == '1) ? sRun : sClear;
    end else begin
      // a dropped $zero write still completes its handshake but leaves the port untouched
      if ((wbAcc || dbgAcc) && !(DROP_ZERO != 0 && grantAddr == '0)) begin
        nextWe = 1'b1;
        nextAddr = grantAddr;
        nextData = grantData;
      end
      nextWait = (dbg_valid && !dbg_ready) ? ((waitCnt == 4'hf) ? waitCnt : waitCnt + 4'd1) : '0;
      if (start_clear) begin
        nextState = sClear;
        nextCnt = '0;
        nextWait = '0;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_STATE;
      cnt <= '0;
      waitCnt <= '0;
      rf_we <= 1'b0;
      rf_wrAddr <= '0;
      rf_wrData <= '0;
    end else begin
      state <= nextState;
      cnt <= nextCnt;
      waitCnt <= nextWait;
      rf_we <= nextWe;
      rf_wrAddr <= nextAddr;
      rf_wrData <= nextData;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: vector table, hand sequences and a randomized run against a queue-based model.
module tb_regfile_write_arbiter;
  logic clk = 1'b0, reset = 1'b1, startClear = 1'b0, wbValid = 1'b0, dbgValid = 1'b0;
  logic [4:0] wbAddr = '0, dbgAddr = '0;
  logic [31:0] wbData = '0, dbgData = '0;
  logic busy0, busy1, wbR0, wbR1, dbgR0, dbgR1, we0, we1;
  logic [4:0] a0, a1;
  logic [31:0] d0, d1;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DROP_ZERO(0)) dut0 (
    .clk(clk), .reset(reset), .start_clear(startClear), .clear_busy(busy0),
    .wb_valid(wbValid), .wb_addr(wbAddr), .wb_data(wbData), .wb_ready(wbR0),
    .dbg_valid(dbgValid), .dbg_addr(dbgAddr), .dbg_data(dbgData), .dbg_ready(dbgR0),
    .rf_we(we0), .rf_wrAddr(a0), .rf_wrData(d0));
  regfile_write_arbiter #(.DROP_ZERO(1)) dut1 (
    .clk(clk), .reset(reset), .start_clear(startClear), .clear_busy(busy1),
    .wb_valid(wbValid), .wb_addr(wbAddr), .wb_data(wbData), .wb_ready(wbR1),
    .dbg_valid(dbgValid), .dbg_addr(dbgAddr), .dbg_data(dbgData), .dbg_ready(dbgR1),
    .rf_we(we1), .rf_wrAddr(a1), .rf_wrData(d1));

  typedef struct {
    logic wbV; logic [4:0] wbA; logic [31:0] wbD;
    logic dbgV; logic [4:0] dbgA; logic [31:0] dbgD;
    logic eWb; logic eDbg; logic eWe0; logic eWe1; logic [4:0] eAddr; logic [31:0] eData;
  } vecT;
  vecT vecs[11];

  logic [4:0] clearQ[$];
  int streak;
  logic busyM, starve, eWb, eDbg, accWb, accDbg, mWe0, mWe1;
  logic [4:0] mA0, mA1, ga, qa;
  logic [31:0] mD0, mD1, gd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rndAddr();
    return ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
  endfunction

  initial begin
    vecs[0]  = '{1'b1, 5'd5, 32'h20, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h20};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h20};
    vecs[2]  = '{1'b1, 5'd0, 32'h1,  1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1};
    vecs[3]  = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h11};
    vecs[4]  = '{1'b1, 5'd2, 32'h12, 1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h12};
    vecs[5]  = '{1'b1, 5'd3, 32'h13, 1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h13};
    vecs[6]  = '{1'b1, 5'd4, 32'h14, 1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h14};
    vecs[7]  = '{1'b1, 5'd9, 32'h99, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF};
    vecs[8]  = '{1'b1, 5'd9, 32'h99, 1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h99};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'h5A5A,     1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 32'h5A5A};
    vecs[10] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'h5,        1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h5};

    // reset state, with requests present to prove readies stay low
    wbValid = 1'b1;
    dbgValid = 1'b1;
    #2;
    chk("rst_we", 32'(we0), 32'd0);
    chk("rst_addr", 32'(a0), 32'd0);
    chk("rst_data", d0, 32'd0);
    chk("rst_busy", 32'(busy0), 32'd1);
    chk("rst_wbready", 32'(wbR0), 32'd0);
    chk("rst_dbgready", 32'(dbgR1), 32'd0);
    tick();
    reset = 1'b0;
    wbValid = 1'b0;
    dbgValid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("clr_busy", 32'(busy0), 32'd1);
      chk("clr_wbready", 32'(wbR0), 32'd0);
      tick();
      chk("clr_we", 32'(we0), 32'd1);
      chk("clr_addr", 32'(a0), 32'(i));
      chk("clr_data", d0, 32'd0);
    end
    #1;
    chk("run_busy", 32'(busy0), 32'd0);
    chk("run_wbready", 32'(wbR0), 32'd1);

    for (int i = 0; i < 11; i++) begin
      wbValid = vecs[i].wbV; wbAddr = vecs[i].wbA; wbData = vecs[i].wbD;
      dbgValid = vecs[i].dbgV; dbgAddr = vecs[i].dbgA; dbgData = vecs[i].dbgD;
      #1;
      chk($sformatf("vec%0d_wbready", i), 32'(wbR0), 32'(vecs[i].eWb));
      chk($sformatf("vec%0d_dbgready", i), 32'(dbgR0), 32'(vecs[i].eDbg));
      chk($sformatf("vec%0d_dbgready_dz", i), 32'(dbgR1), 32'(vecs[i].eDbg));
      tick();
      chk($sformatf("vec%0d_we", i), 32'(we0), 32'(vecs[i].eWe0));
      chk($sformatf("vec%0d_we_dz", i), 32'(we1), 32'(vecs[i].eWe1));
      chk($sformatf("vec%0d_addr", i), 32'(a0), 32'(vecs[i].eAddr));
      chk($sformatf("vec%0d_data", i), d0, vecs[i].eData);
    end
    wbValid = 1'b0;
    dbgValid = 1'b0;

    // start_clear in RUN: the same-cycle wb write still goes out before the zero fill
    wbValid = 1'b1; wbAddr = 5'd12; wbData = 32'hAB; startClear = 1'b1;
    #1;
    chk("sc_wbready", 32'(wbR0), 32'd1);
    tick();
    startClear = 1'b0; wbAddr = 5'd13; wbData = 32'hCD;
    chk("sc_we", 32'(we0), 32'd1);
    chk("sc_addr", 32'(a0), 32'd12);
    chk("sc_data", d0, 32'hAB);
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("sc_clr_busy", 32'(busy0), 32'd1);
      chk("sc_clr_wbready", 32'(wbR0), 32'd0);
      tick();
      chk("sc_clr_we", 32'(we0), 32'd1);
      chk("sc_clr_addr", 32'(a0), 32'(i));
      chk("sc_clr_data", d0, 32'd0);
    end
    #1;
    chk("sc_done_busy", 32'(busy0), 32'd0);
    chk("sc_done_wbready", 32'(wbR0), 32'd1);
    tick();
    chk("sc_after_addr", 32'(a0), 32'd13);
    chk("sc_after_data", d0, 32'hCD);
    wbValid = 1'b0;

    // reset in the middle of a clear restarts the sequence from address 0
    startClear = 1'b1;
    tick();
    startClear = 1'b0;
    repeat (10) tick();
    chk("mid_addr", 32'(a0), 32'd9);
    #2;
    reset = 1'b1;
    wbValid = 1'b1;
    #1;
    chk("mid_rst_we", 32'(we0), 32'd0);
    chk("mid_rst_we_dz", 32'(we1), 32'd0);
    chk("mid_rst_addr", 32'(a0), 32'd0);
    chk("mid_rst_wbready", 32'(wbR0), 32'd0);
    chk("mid_rst_busy", 32'(busy0), 32'd1);
    tick();
    reset = 1'b0;
    wbValid = 1'b0;
    tick();
    chk("restart_we", 32'(we0), 32'd1);
    chk("restart_addr0", 32'(a0), 32'd0);
    tick();
    chk("restart_addr1", 32'(a0), 32'd1);

    // randomized run against the model, starting from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clearQ.delete();
    for (int k = 0; k < 32; k++) clearQ.push_back(5'(k));
    streak = 0;
    mWe0 = 1'b0; mWe1 = 1'b0; mA0 = '0; mA1 = '0; mD0 = '0; mD1 = '0;
    for (int n = 0; n < 600; n++) begin
      busyM = clearQ.size() != 0;
      starve = streak >= 4;
      eWb = !busyM && (!starve || !dbgValid);
      eDbg = !busyM && dbgValid && (!wbValid || starve);
      accWb = wbValid && eWb;
      accDbg = dbgValid && eDbg;
      #1;
      chk("rnd_busy", 32'(busy0), 32'(busyM));
      chk("rnd_wbready", 32'(wbR0), 32'(eWb));
      chk("rnd_dbgready", 32'(dbgR0), 32'(eDbg));
      chk("rnd_wbready_dz", 32'(wbR1), 32'(eWb));
      if (busyM) begin
        qa = clearQ.pop_front();
        mWe0 = 1'b1; mA0 = qa; mD0 = '0;
        mWe1 = 1'b1; mA1 = qa; mD1 = '0;
        streak = 0;
      end else begin
        mWe0 = 1'b0;
        mWe1 = 1'b0;
        if (accWb || accDbg) begin
          ga = accWb ? wbAddr : dbgAddr;
          gd = accWb ? wbData : dbgData;
          mWe0 = 1'b1; mA0 = ga; mD0 = gd;
          if (ga != 5'd0) begin
            mWe1 = 1'b1; mA1 = ga; mD1 = gd;
          end
        end
        streak = (dbgValid && !eDbg) ? ((streak < 15) ? streak + 1 : 15) : 0;
        if (startClear) begin
          for (int k = 0; k < 32; k++) clearQ.push_back(5'(k));
          streak = 0;
        end
      end
      tick();
      chk("rnd_we", 32'(we0), 32'(mWe0));
      chk("rnd_addr", 32'(a0), 32'(mA0));
      chk("rnd_data", d0, mD0);
      chk("rnd_we_dz", 32'(we1), 32'(mWe1));
      chk("rnd_addr_dz", 32'(a1), 32'(mA1));
      chk("rnd_data_dz", d1, mD1);
      if (!wbValid || accWb) begin
        wbValid = $urandom_range(0, 2) != 0;
        wbAddr = rndAddr();
        wbData = $urandom;
      end
      if (!dbgValid || accDbg) begin
        dbgValid = $urandom_range(0, 2) != 0;
        dbgAddr = rndAddr();
        dbgData = $urandom;
      end
      startClear = $urandom_range(0, 79) == 0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of `reg_file` and shares it between two requesters: pipeline writeback (wb) and the debug/loader port (dbg).
- Uses valid/ready handshakes with a starvation bound for dbg.
- Runs a clear sequencer that writes zero to every register after reset or on command.
- Sits between the writeback stage, the debug interface and `reg_file.we/wrAddr/wrData`.

Parameters:
- DATA_WIDTH, 32: write data width.
- ADDR_WIDTH, 5: register address width; register count = 2**ADDR_WIDTH.
- MAX_WAIT, 4: number of consecutive cycles dbg may be refused before it is forced priority (1..15).
- CLEAR_ON_RESET, 1: 1 = enter CLEAR after reset release; 0 = enter RUN.
- DROP_ZERO, 0: 1 = accepted writes to address 0 are consumed but not forwarded (MIPS $zero).

Ports:
- clk, in, 1: clock; all state updates on rising edge.
- reset, in, 1: asynchronous, active-high reset.
- start_clear, in, 1: pulse; in RUN, starts a full clear sequence.
- clear_busy, out, 1: high while the state is CLEAR.
- wb_valid, in, 1: writeback request.
- wb_addr, in, ADDR_WIDTH: writeback register address.
- wb_data, in, DATA_WIDTH: writeback data.
- wb_ready, out, 1: writeback accepted this cycle when wb_valid && wb_ready.
- dbg_valid, in, 1: debug write request.
- dbg_addr, in, ADDR_WIDTH: debug register address.
- dbg_data, in, DATA_WIDTH: debug data.
- dbg_ready, out, 1: debug accepted this cycle when dbg_valid && dbg_ready.
- rf_we, out, 1: to `reg_file.we`, registered.
- rf_wrAddr, out, ADDR_WIDTH: to `reg_file.wrAddr`, registered.
- rf_wrData, out, DATA_WIDTH: to `reg_file.wrData`, registered.

Behaviour:
- Reset values (asynchronous): rf_we=0, rf_wrAddr=0, rf_wrData=0, clear counter=0, wait_cnt=0.
  - State = CLEAR if CLEAR_ON_RESET, else RUN.
  - clear_busy follows the state.
  - wb_ready and dbg_ready are 0 while reset is high.
- FSM states: CLEAR and RUN.
- CLEAR:
  - wb_ready=0 and dbg_ready=0.
  - Each edge: rf_we<=1, rf_wrAddr<=cnt, rf_wrData<=0, cnt<=cnt+1.
  - On the edge where cnt == 2**ADDR_WIDTH-1: state<=RUN and cnt<=0.
  - Exactly 2**ADDR_WIDTH consecutive rf_we pulses occur, addresses ascending 0..31.
  - start_clear is ignored in CLEAR.
- RUN:
  - starve = (wait_cnt >= MAX_WAIT).
  - dbg_ready = dbg_valid && (!wb_valid || starve); wb_ready = !starve || !dbg_valid. Both are combinational.
  - At most one request is accepted per cycle. wb has priority unless starve.
  - On acceptance, on the next edge: rf_we<=1, rf_wrAddr<=granted addr, rf_wrData<=granted data. Latency is 1 cycle to the rf_* outputs; `reg_file` commits on the following edge.
  - If DROP_ZERO=1 and the granted addr == 0, the handshake completes but rf_we<=0.
  - With no acceptance: rf_we<=0; rf_wrAddr and rf_wrData hold their values.
  - wait_cnt increments (saturating at 15) when dbg_valid && !dbg_ready. It clears on dbg acceptance or when dbg_valid is low.
  - start_clear in RUN: the current cycle's acceptance still proceeds. Next state = CLEAR with cnt=0 and wait_cnt=0.
- Simultaneous start_clear and reset: reset wins.
- Reset asserted mid-CLEAR or mid-write: the pending rf_we drops immediately. After release, the sequence restarts at address 0 (if CLEAR_ON_RESET).
- Requesters must hold valid, addr and data stable until accepted. The arbiter does not buffer any request.

Test Plan:
- Reset release with CLEAR_ON_RESET=1 -> clear_busy=1 for 32 cycles. rf_we=1 with rf_wrAddr 0..31 ascending and rf_wrData=0. Both readies=0. RUN after the 32nd edge.
- RUN, wb_valid=1, wb_addr=5, wb_data=0x00000020 -> wb_ready=1. Next cycle rf_we=1, rf_wrAddr=5, rf_wrData=0x00000020. `reg_file` read of addr 5 returns 0x20.
- wb_valid and dbg_valid held high, MAX_WAIT=4, dbg_addr=7, dbg_data=0xDEADBEEF:
  - wb is granted in cycles 1-4.
  - In cycle 5: wb_ready=0, dbg_ready=1.
  - Next cycle rf_wrAddr=7, rf_wrData=0xDEADBEEF. wait_cnt returns to 0.
- DROP_ZERO=1, wb_addr=0, wb_data=1 -> wb_ready=1, rf_we stays 0. With DROP_ZERO=0 -> rf_we=1, rf_wrAddr=0, rf_wrData=1.
- start_clear pulse in RUN with wb_valid=1 -> that cycle's wb write is issued. Then 32 zero writes occur with readies=0. wb_ready returns to 1 after the clear.
- reset asserted during CLEAR at cnt=10 -> rf_we=0 immediately, without waiting for a clock edge. After release, clear writes restart at rf_wrAddr=0.
